ahb_ram_slave: RTL and testbench
================================

# ahb_ram_slave

AHB-Lite data-RAM slave sitting directly downstream of the AHB interconnect: selected by the interconnect's RAM select, it consumes the forwarded address-phase control and write data. It returns read data, ready and response to the interconnect's response mux. It holds a word-organised memory, supports byte/half/word accesses with sign or zero extension, inserts a configurable number of wait states and generates the two-cycle AHB ERROR response.

## Interface
- DEPTH_WORDS, 1024: memory depth in 32-bit words (power of two); word index = haddr[log2(DEPTH_WORDS)+1:2].
- WAIT_STATES, 1: wait cycles per OKAY transfer (0..7).
- hclk  in  1  clock. One clock; all state updates on the rising edge of hclk.
- hreset  in  1  reset. Synchronous and active-high.
- hsel  in  1  slave select (RAM select from the interconnect).
- haddr  in  32  address.
- htrans  in  2  transfer type; 2 = NONSEQ, 3 = SEQ, 0/1 = IDLE/BUSY.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word; others illegal.
- hprot  in  4  protection; accepted and ignored.
- hwdata  in  32  write data, valid in the data phase.
- is_signed  in  1  read extension: 1 = sign-extend, 0 = zero-extend.
- hready  in  1  bus-wide ready; address phase sampled only when high.
- hrdata  out  32  read data, right-justified and extended.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Transfer accepted on a rising edge where hsel & hready & htrans[1]. Registered at acceptance: haddr, hwrite, hsize, is_signed.
- Non-accepted cycles, including IDLE/BUSY, unselected and hready low, leave the slave in IDLE: zero-wait OKAY.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: accept legal transfer → WAIT if WAIT_STATES>0, else complete in the next cycle (stay IDLE, hreadyout=1). Accept illegal transfer → ERR1.
  - WAIT: down-counter loaded with WAIT_STATES; hreadyout=0 while counter≠0. At 0, hreadyout=1 and the transfer completes. In that completing cycle a new address phase may be accepted, giving back-to-back transfers.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1. A new transfer may be accepted here; otherwise → IDLE.
- Illegal transfer: hsize>2 → ERROR. With RAM_ALIGN_CHECK_EN, misalignment also → ERROR. Addresses beyond DEPTH_WORDS wrap modulo depth.
- Write: performed on the edge completing the data phase (hreadyout=1). Byte lanes are little-endian.
  - Byte writes lane haddr[1:0], taking the data from hwdata[8*lane+7:8*lane].
  - Half writes lanes {haddr[1],0} and {haddr[1],1}.
  - Word writes all four lanes.
- Read: the selected byte/half/word is shifted to bit 0 and extended to 32 bits per the registered is_signed. hrdata is valid when hreadyout=1 in an OKAY data phase; otherwise 0.
- Read of a word written in the immediately preceding transfer returns the new data.
- ERROR transfers never modify memory; hrdata=0.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, counter=0. Memory contents are not reset.
- hreset asserted mid-transfer: the pending write is dropped, the FSM returns to IDLE the next cycle and outputs return to reset values.
- OKAY latency: data phase lasts WAIT_STATES+1 cycles after the address-phase edge.
- ERROR: always exactly 2 data-phase cycles, independent of WAIT_STATES.
- hsel deasserted during a data phase has no effect; the data phase completes.
- hresp changes only at state edges; no combinational path from address-phase inputs to hreadyout/hresp.

## Configuration
- RAM_ALIGN_CHECK_EN defined: a half-word transfer with haddr[0]=1, or a word transfer with haddr[1:0]≠0, gives an ERROR response and no write.
- Undefined: haddr[0] is ignored for half-word transfers and haddr[1:0] for word transfers (address forced to alignment); only hsize>2 errors.

## Test plan
- Reset: hold hreset 2 cycles → hreadyout=1, hresp=0, hrdata=0.
- WAIT_STATES=1, word write 0xDEADBEEF to 0x10, then word read 0x10 → each data phase 2 cycles (hreadyout 0 then 1); read returns 0xDEADBEEF; back-to-back write→read shows no extra bubble.
- Byte write 0x80 to 0x21, then byte read 0x21 → is_signed=1 gives 0xFFFFFF80, is_signed=0 gives 0x00000080; other lanes of word 0x20 unchanged.
- hsize=3 read → cycle 1 hreadyout=0/hresp=1, cycle 2 hreadyout=1/hresp=1, memory unchanged. Then word read 0x14 → OKAY.
- Word write to 0x22 → with RAM_ALIGN_CHECK_EN: ERROR and 0x20 unchanged; without: word written to 0x20.
- Reset asserted during a write's wait state → target word unchanged, and a read afterwards returns the old value.

Source files
------------

// File: rtl/ahb_ram_slave.sv
// AHB-Lite word-organised data RAM slave with byte/half/word access, configurable wait states and ERROR response.
// Optional `RAM_ALIGN_CHECK_EN: misaligned half/word transfers return ERROR instead of being force-aligned.
module ahb_ram_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        is_signed,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            dph_q, dph_d;
  logic            wr_q, wr_d;
  logic            sgn_q, sgn_d;
  logic [1:0]      size_q, size_d;
  logic [1:0]      off_q, off_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept, illegal, wr_en, rd_vld;
  logic [1:0]      off_al;
  logic [3:0]      be;
  logic [31:0]     rd_sh, rd_ext;
  logic            unused_ok;

  assign unused_ok = ^{hprot, htrans[0], haddr[31:AW+2]};

  // Only sample an address phase while this slave is itself ready.
  assign accept = hsel & hready & htrans[1] & hreadyout;

`ifdef RAM_ALIGN_CHECK_EN
  assign illegal = (hsize > 3'd2) | ((hsize == 3'd1) & haddr[0]) |
                   ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
`else
  assign illegal = (hsize > 3'd2);
`endif

  always_comb begin
    off_al = haddr[1:0];
    if (hsize == 3'd1) off_al[0] = 1'b0;
    else if (hsize == 3'd2) off_al = 2'b00;
  end

  assign hreadyout = !((state_q == S_ERR1) || ((state_q == S_WAIT) && (cnt_q != 3'd0)));
  assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign wr_en     = dph_q & hreadyout & wr_q;
  assign rd_vld    = dph_q & hreadyout & ~wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dph_d   = dph_q;
    wr_d    = wr_q;
    sgn_d   = sgn_q;
    size_d  = size_q;
    off_d   = off_q;
    idx_d   = idx_q;
    if (hreadyout) begin
      state_d = S_IDLE;
      dph_d   = 1'b0;
      if (accept) begin
        wr_d   = hwrite;
        sgn_d  = is_signed;
        size_d = hsize[1:0];
        off_d  = off_al;
        idx_d  = haddr[AW+1:2];
        if (illegal) begin
          state_d = S_ERR1;
        end else begin
          dph_d = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end
        end
      end
    end else if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      dph_q   <= 1'b0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dph_q   <= dph_d;
      wr_q    <= wr_d;
      sgn_q   <= sgn_d;
      size_q  <= size_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    be = 4'b0001 << off_q;
      2'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Byte lanes of hwdata map straight onto the same lanes of the word.
  always_ff @(posedge hclk) begin
    if (!hreset && wr_en) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
    end
  end

  always_comb begin
    rd_sh = mem[idx_q] >> {off_q, 3'b000};
    case (size_q)
      2'd0:    rd_ext = {{24{sgn_q & rd_sh[7]}}, rd_sh[7:0]};
      2'd1:    rd_ext = {{16{sgn_q & rd_sh[15]}}, rd_sh[15:0]};
      default: rd_ext = rd_sh;
    endcase
    hrdata = rd_vld ? rd_ext : 32'd0;
  end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Randomized bench for ahb_ram_slave: byte-array reference model, cycle-exact ready/resp checks.
module tb_ahb_ram_slave;
  localparam int DEPTH = 1024;
  localparam int WS    = 1;
  localparam int NB    = 64;

  logic        hclk = 1'b0;
  logic        hreset, hsel, hwrite, is_signed, hready;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        hreadyout, hresp;

  always #5 hclk = ~hclk;

  ahb_ram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .is_signed(is_signed), .hready(hready), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp)
  );

  typedef struct {
    logic        vld;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic        sgn;
    logic [31:0] wd;
  } xfer_t;

  xfer_t      q[$];
  xfer_t      dp;
  int         dp_cyc;
  logic [7:0] mem_m [NB];
  bit         known [NB];
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit illegal(input xfer_t t);
    if (t.sz > 3'd2) return 1'b1;
`ifdef RAM_ALIGN_CHECK_EN
    if (t.sz == 3'd1 && t.addr[0]) return 1'b1;
    if (t.sz == 3'd2 && t.addr[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int nbytes(input xfer_t t);
    return 1 << int'(t.sz);
  endfunction

  // Region offset rounded down to the access size (upper address bits alias).
  function automatic int base(input xfer_t t);
    int o;
    o = int'(t.addr[5:0]);
    return o - (o % nbytes(t));
  endfunction

  task automatic model_wr(input xfer_t t);
    int b, n;
    b = base(t);
    n = nbytes(t);
    for (int i = 0; i < n; i++) begin
      mem_m[b+i] = t.wd[8*((b+i)%4) +: 8];
      known[b+i] = 1'b1;
    end
  endtask

  task automatic model_rd(input xfer_t t, output bit ok, output logic [31:0] v);
    int b, n;
    b = base(t);
    n = nbytes(t);
    ok = 1'b1;
    v  = 32'd0;
    for (int i = 0; i < n; i++) begin
      ok = ok & known[b+i];
      v  = v | (32'(mem_m[b+i]) << (8*i));
    end
    if (t.sgn && v[8*n-1])
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
  endtask

  function automatic xfer_t mk(input bit wr, input int sz, input logic [31:0] addr,
                               input bit sgn, input logic [31:0] wd);
    xfer_t t;
    t.vld = 1'b1; t.wr = wr; t.sz = 3'(sz); t.addr = addr; t.sgn = sgn; t.wd = wd;
    return t;
  endfunction

  function automatic xfer_t rnd_xfer();
    xfer_t t;
    t.vld  = ($urandom_range(0, 7) != 0);
    t.wr   = 1'($urandom);
    t.sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    t.addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, NB-1));
    t.sgn  = 1'($urandom);
    t.wd   = $urandom;
    return t;
  endfunction

  // One bus cycle: check the data phase in flight, then drive the next address phase.
  task automatic step();
    xfer_t       a;
    bit          rdy, ok;
    logic [31:0] ev;
    @(negedge hclk);
    if (dp.vld) hwdata = dp.wd;
    rdy = hreadyout;
    if (dp.vld) begin
      dp_cyc++;
      if (illegal(dp)) begin
        chk("err_ready", 32'(hreadyout), 32'(dp_cyc == 2));
        chk("err_resp", 32'(hresp), 32'd1);
        chk("err_rdata", hrdata, 32'd0);
      end else begin
        chk("ok_ready", 32'(hreadyout), 32'(dp_cyc == WS + 1));
        chk("ok_resp", 32'(hresp), 32'd0);
        if (hreadyout) begin
          if (dp.wr) model_wr(dp);
          else begin
            model_rd(dp, ok, ev);
            if (ok) chk("rdata", hrdata, ev);
          end
        end
      end
    end else begin
      chk("idle_ready", 32'(hreadyout), 32'd1);
      chk("idle_resp", 32'(hresp), 32'd0);
      chk("idle_rdata", hrdata, 32'd0);
    end
    a.vld = 1'b0;
    if (rdy && q.size() > 0) a = q.pop_front();
    hready = rdy;
    hprot  = 4'($urandom);
    if (!rdy) begin
      // Bus stalled: anything on the address lines must be ignored.
      hsel = 1'($urandom); htrans = 2'($urandom); haddr = $urandom;
      hwrite = 1'($urandom); hsize = 3'($urandom); is_signed = 1'($urandom);
    end else if (a.vld) begin
      hsel = 1'b1; htrans = {1'b1, 1'($urandom)}; haddr = a.addr;
      hwrite = a.wr; hsize = a.sz; is_signed = a.sgn;
    end else begin
      hsel = 1'($urandom);
      htrans = hsel ? {1'b0, 1'($urandom)} : 2'($urandom);
      haddr = $urandom; hwrite = 1'($urandom); hsize = 3'($urandom);
    end
    if (rdy) begin
      dp     = a;
      dp_cyc = 0;
    end
  endtask

  task automatic run_q();
    int guard;
    guard = 0;
    while ((q.size() > 0 || dp.vld) && guard < 5000) begin
      step();
      guard++;
    end
    if (guard >= 5000) chk("drain_timeout", 32'(q.size()), 32'd0);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    dp = '{default: '0};
    dp_cyc = 0;
    for (int i = 0; i < NB; i++) begin mem_m[i] = 8'h00; known[i] = 1'b0; end
    hreset = 1'b1; hsel = 1'b0; haddr = 32'd0; htrans = 2'd0; hwrite = 1'b0;
    hsize = 3'd0; hprot = 4'd0; hwdata = 32'd0; is_signed = 1'b0; hready = 1'b1;
    repeat (2) @(negedge hclk);
    chk("rst_ready", 32'(hreadyout), 32'd1);
    chk("rst_resp", 32'(hresp), 32'd0);
    chk("rst_rdata", hrdata, 32'd0);
    hreset = 1'b0;

    for (int w = 0; w < NB/4; w++) q.push_back(mk(1, 2, 32'(4*w), 0, $urandom));
    q.push_back(mk(1, 2, 32'h10, 0, 32'hDEAD_BEEF));
    q.push_back(mk(0, 2, 32'h10, 0, 32'd0));
    q.push_back(mk(1, 0, 32'h21, 0, 32'h0000_8000));
    q.push_back(mk(0, 0, 32'h21, 1, 32'd0));
    q.push_back(mk(0, 0, 32'h21, 0, 32'd0));
    q.push_back(mk(0, 2, 32'h20, 0, 32'd0));
    q.push_back(mk(0, 3, 32'h14, 0, 32'd0));
    q.push_back(mk(1, 3, 32'h14, 0, 32'hFFFF_FFFF));
    q.push_back(mk(0, 2, 32'h14, 0, 32'd0));
    q.push_back(mk(1, 2, 32'h22, 0, 32'hA5A5_5A5A));
    q.push_back(mk(0, 2, 32'h20, 0, 32'd0));
    q.push_back(mk(1, 1, 32'h2B, 0, 32'hBEEF_0000));
    q.push_back(mk(0, 1, 32'h2A, 1, 32'd0));
    run_q();

    for (int i = 0; i < 300; i++) q.push_back(rnd_xfer());
    run_q();

    // Reset during a write's wait state drops the write.
    @(negedge hclk);
    hready = 1'b1; hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
    haddr = 32'h8; is_signed = 1'b0;
    @(negedge hclk);
    chk("rst_mid_wait", 32'(hreadyout), 32'd0);
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h1234_5678; hreset = 1'b1;
    @(negedge hclk);
    hreset = 1'b0;
    chk("rst_mid_ready", 32'(hreadyout), 32'd1);
    chk("rst_mid_resp", 32'(hresp), 32'd0);
    chk("rst_mid_rdata", hrdata, 32'd0);
    q.push_back(mk(0, 2, 32'h8, 0, 32'd0));
    run_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
